ps2_direction_decoder: RTL and testbench

Receives PS/2 keyboard frames and turns make/break scancodes into the one-hot `direction` and `boom` controls consumed by the plane movement/rendering block. Sits between the board's PS/2 pins and the game logic, in the single `clk` domain. It performs synchronization, clock-glitch filtering, frame checking, `E0`/`F0` prefix tracking and held-key bookkeeping.

---
 rtl/ps2_direction_decoder.sv | 189 ++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 receiver and make/break decoder driving plane direction and boom controls
module ps2_direction_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] direction,
  output logic       boom,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO       = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt_lvl;
  logic [FW-1:0] fcnt;
  logic          strobe, bit_smp;
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout, done, good;
  logic          ext, brk, space;
  logic [3:0]    held, last;
  logic [3:0]    key_dir;
  logic          key_space;

  // two-flop synchronizers; idle-high lines reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // glitch filter: level flips after FILTER_LEN consecutive differing samples;
  // the falling flip produces a one-cycle strobe carrying the data sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_lvl <= 1'b1;
      fcnt     <= '0;
      strobe   <= 1'b0;
      bit_smp  <= 1'b1;
    end else begin
      strobe  <= filt_lvl && !clk_sync[1] && (fcnt == FILT_LAST);
      bit_smp <= data_sync[1];
      if (clk_sync[1] == filt_lvl) begin
        fcnt <= '0;
      end else if (fcnt == FILT_LAST) begin
        filt_lvl <= clk_sync[1];
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign timeout = (tcnt >= TMO);
  assign done    = (state == STOP) && strobe;
  assign good    = bit_smp && (^{par_bit, shreg});

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // receiver next-state logic, with the frame timeout overriding to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strobe && !bit_smp) state_next = DATA;
      DATA:    if (strobe && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (strobe) state_next = STOP;
      STOP:    if (strobe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !strobe && timeout) state_next = IDLE;
  end

  // receiver datapath, frame result pulses and inter-strobe timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= done && good;
      frame_err  <= done && !good;
      if (done && good) code <= shreg;
      if (state == IDLE || strobe) tcnt <= '0;
      else if (!timeout)           tcnt <= tcnt + 1'b1;
      if (strobe) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {bit_smp, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_bit <= bit_smp;
          default: ;
        endcase
      end
    end
  end

  // scancode to key map, qualified by the extended prefix
  always_comb begin
    key_dir   = 4'b0000;
    key_space = 1'b0;
    if (ext) begin
      case (code)
        8'h75:   key_dir = 4'b0001;
        8'h72:   key_dir = 4'b0010;
        8'h6B:   key_dir = 4'b0100;
        8'h74:   key_dir = 4'b1000;
        default: ;
      endcase
    end else begin
      case (code)
        8'h1D:   key_dir = 4'b0001;
        8'h1B:   key_dir = 4'b0010;
        8'h1C:   key_dir = 4'b0100;
        8'h23:   key_dir = 4'b1000;
        8'h29:   key_space = 1'b1;
        default: ;
      endcase
    end
  end

  // prefix tracking and held-key bookkeeping, one cycle after code_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      held  <= '0;
      last  <= '0;
      space <= 1'b0;
    end else if (code_valid) begin
      if (code == 8'hE0) begin
        ext <= 1'b1;
      end else if (code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (brk) begin
          held <= held & ~key_dir;
          if (key_space) space <= 1'b0;
        end else begin
          held <= held | key_dir;
          if (key_dir != 4'b0000) last <= key_dir;
          if (key_space) space <= 1'b1;
        end
      end
    end
  end

  // most recent held key wins, else fixed priority up > down > left > right
  always_comb begin
    direction = 4'b0000;
    if ((last & held) != 4'b0000) direction = last;
    else if (held[0])             direction = 4'b0001;
    else if (held[1])             direction = 4'b0010;
    else if (held[2])             direction = 4'b0100;
    else if (held[3])             direction = 4'b1000;
  end

  assign boom = space;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - directed self-checking bench for ps2_direction_decoder
module tb_ps2_direction_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] direction;
  logic       boom;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int exp_cv = 0;
  int exp_fe = 0;

  ps2_direction_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .direction(direction), .boom(boom), .code(code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err)  fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, ~^b ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      if (glitch) begin
        repeat (14) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 2) @(posedge clk);
        ps2_clk = 1'b1;
      end
      repeat (10) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (40) @(posedge clk);
    if (nbits == 11) begin
      if (bad) exp_fe++;
      else     exp_cv++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("reset_dir", direction, 4'b0000);
    check("reset_boom", boom, 1'b0);
    check("reset_code", code, 8'h00);
    check("reset_cv", code_valid, 1'b0);
    check("reset_fe", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (10000) @(posedge clk);
    #1;
    check("idle_cv_cnt", cv_cnt, 0);
    check("idle_fe_cnt", fe_cnt, 0);
    check("idle_dir", direction, 4'b0000);

    send(8'hE0);
    check("e0_code", code, 8'hE0);
    check("e0_cv_cnt", cv_cnt, exp_cv);
    send(8'h75);
    check("up_code", code, 8'h75);
    check("up_cv_cnt", cv_cnt, exp_cv);
    check("up_dir", direction, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_rel_dir", direction, 4'b0000);

    send(8'h1C);
    check("left_dir", direction, 4'b0100);
    send(8'h23);
    check("right_dir", direction, 4'b1000);
    send(8'hF0); send(8'h23);
    check("right_rel_dir", direction, 4'b0100);

    send_frame(8'h29, 1'b1, 11, 1'b0);
    check("bad_fe_cnt", fe_cnt, exp_fe);
    check("bad_cv_cnt", cv_cnt, exp_cv);
    check("bad_boom", boom, 1'b0);
    send(8'h29);
    check("space_boom", boom, 1'b1);
    check("space_code", code, 8'h29);

    send(8'hF0); send(8'h29);
    check("space_rel_boom", boom, 1'b0);
    send_frame(8'h29, 1'b0, 5, 1'b0);
    repeat (TMO + 500) @(posedge clk);
    check("tmo_cv_cnt", cv_cnt, exp_cv);
    send(8'h29);
    check("tmo_fe_cnt", fe_cnt, exp_fe);
    check("tmo_code", code, 8'h29);
    check("tmo_boom", boom, 1'b1);
    check("tmo_cv_cnt2", cv_cnt, exp_cv);

    send(8'hF0); send(8'h1C);
    check("left_rel_dir", direction, 4'b0000);
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(posedge clk);
    end
    check("glitch_idle_cv", cv_cnt, exp_cv);
    check("glitch_idle_fe", fe_cnt, exp_fe);
    send_frame(8'h1D, 1'b0, 11, 1'b1);
    check("glitch_code", code, 8'h1D);
    check("glitch_cv_cnt", cv_cnt, exp_cv);
    check("glitch_fe_cnt", fe_cnt, exp_fe);
    check("glitch_dir", direction, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
